// File: rtl/std_mem_reader_pkg.sv
// std_mem_reader_pkg
//   Shared definitions for the 1-D memory reader: the controller state
//   encoding and the address wrap helper used when walking the memory.
package std_mem_reader_pkg;

  // Controller states: waiting for go, streaming words, completion pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Next address in a walk over a memory of 'size' words. The wrap point is
  // the memory size, which may be smaller than the address space.
  function automatic int unsigned next_addr(input int unsigned cur,
                                            input int unsigned size);
    return (cur == size - 32'd1) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/std_mem_reader_out_stage.sv
// std_mem_reader_out_stage
//   One-entry valid/ready register slice placed between the memory read path
//   and the output stream. It accepts a new word whenever it is empty or is
//   handing its current word downstream in the same cycle, so a stream with
//   a permanently ready consumer keeps full throughput.
//   Only compiled when STD_MEM_D1_READER_OUT_REG_EN is defined, since it is
//   only instantiated in that configuration.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_valid/o_ready     upstream handshake (o_ready = slice can take a word)
//   i_data/i_last       upstream payload and end-of-transfer marker
//   o_valid/i_ready     downstream handshake
//   o_data/o_last       registered payload and end-of-transfer marker
`ifdef STD_MEM_D1_READER_OUT_REG_EN
module std_mem_reader_out_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_last;
  logic             w_load;

  assign o_ready = !r_valid || i_ready;
  assign w_load  = i_valid && o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule
`endif

// File: rtl/std_mem_d1_reader.sv
// std_mem_d1_reader
//   Drains a contiguous, wrapping address range of a 1-D memory onto a
//   valid/ready stream, started by go and finished with a done pulse.
//   Configuration macro: STD_MEM_D1_READER_OUT_REG_EN inserts a one-entry
//   register slice on the output stream (first beat one cycle later, no
//   combinational path from mem_read_data to out_data).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   go, base_addr, len           start request and range (sampled in IDLE)
//   mem_addr0, mem_write_data,
//   mem_write_en, mem_read_data  memory initiator port (read only)
//   out_data/out_valid/out_ready/out_last   output stream
//   busy, done, err              status; err qualifies done
module std_mem_d1_reader
  import std_mem_reader_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                go,
  input  logic [IDX_SIZE-1:0] base_addr,
  input  logic [IDX_SIZE:0]   len,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic [WIDTH-1:0]    mem_write_data,
  output logic                mem_write_en,
  input  logic [WIDTH-1:0]    mem_read_data,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [IDX_SIZE:0] SIZE_W  = (IDX_SIZE+1)'(SIZE);
  localparam logic [IDX_SIZE:0] REM_ONE = (IDX_SIZE+1)'(1);
  localparam logic [IDX_SIZE:0] REM_TWO = (IDX_SIZE+1)'(2);
  localparam int unsigned       SIZE_U  = SIZE;

  state_t              r_state;
  logic [IDX_SIZE-1:0] r_cur;
  logic [IDX_SIZE:0]   r_rem;     // words still to be fetched from memory
  logic                r_valid;   // fetch-side stream valid
  logic                r_last;    // fetch-side word is the final one
  logic                r_done;
  logic                r_err;
  logic                r_err_q;   // error result latched with go
  logic                r_hold;    // empty transfer: one extra cycle before done

  logic [IDX_SIZE:0]   w_len_clip;
  logic                w_base_bad;
  logic                w_s_ready;
  logic                w_s_beat;
  logic                w_end;

  assign w_len_clip = (len > SIZE_W) ? SIZE_W : len;
  assign w_base_bad = ({1'b0, base_addr} >= SIZE_W);
  assign w_s_beat   = r_valid && w_s_ready;
  // The transfer ends when the final word leaves the block, which with the
  // register slice is later than when it was fetched.
  assign w_end      = out_valid && out_ready && out_last;

`ifdef STD_MEM_D1_READER_OUT_REG_EN
  std_mem_reader_out_stage #(
    .WIDTH (WIDTH)
  ) u_out_stage (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_valid (r_valid),
    .o_ready (w_s_ready),
    .i_data  (mem_read_data),
    .i_last  (r_last),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_last  (out_last)
  );
`else
  assign w_s_ready = out_ready;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  // Forced to zero when no word is presented so reset leaves out_data at 0.
  assign out_data  = r_valid ? mem_read_data : '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_err_q <= 1'b0;
      r_hold  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (go) begin
            if (w_base_bad) begin
              r_state <= FIN;
              r_err_q <= 1'b1;
              r_hold  <= 1'b1;
            end else if (len == '0) begin
              r_state <= FIN;
              r_err_q <= 1'b0;
              r_hold  <= 1'b1;
            end else begin
              r_state <= READ;
              r_cur   <= base_addr;
              r_rem   <= w_len_clip;
              r_valid <= 1'b1;
              r_last  <= (w_len_clip == REM_ONE);
              r_err_q <= 1'b0;
            end
          end
        end
        READ: begin
          if (w_s_beat) begin
            r_rem   <= r_rem - REM_ONE;
            r_last  <= (r_rem == REM_TWO);
            r_valid <= (r_rem != REM_ONE);
            // The address stays on the final word so mem_addr0 holds it
            // through FIN and IDLE.
            if (r_rem != REM_ONE) begin
              r_cur <= IDX_SIZE'(next_addr(32'(r_cur), SIZE_U));
            end
          end
          if (w_end) begin
            r_state <= FIN;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        FIN: begin
          if (r_hold) begin
            r_hold <= 1'b0;
            r_done <= 1'b1;
            r_err  <= r_err_q;
          end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_addr0      = r_cur;
  assign mem_write_data = '0;
  assign mem_write_en   = 1'b0;
  assign busy           = (r_state != IDLE);
  assign done           = r_done;
  assign err            = r_err;

endmodule

// File: tb/tb_std_mem_d1_reader.sv
// Bench for std_mem_d1_reader: memory model with mem[i] = i + 100 and a
// scoreboard of expected stream beats checked by a negedge monitor.
module tb_std_mem_d1_reader;

  localparam int W   = 32;
  localparam int SZ  = 16;
  localparam int IW  = 5;
`ifdef STD_MEM_D1_READER_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [W-1:0]  data;
    logic          last;
    logic [IW-1:0] addr;
  } beat_t;

  logic          clk;
  logic          reset_n;
  logic          go;
  logic [IW-1:0] base_addr;
  logic [IW:0]   len;
  logic [IW-1:0] mem_addr0;
  logic [W-1:0]  mem_write_data;
  logic          mem_write_en;
  logic [W-1:0]  mem_read_data;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;

  logic [W-1:0]  mem [0:SZ-1];
  beat_t         q[$];
  beat_t         mon_e;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            beats = 0;
  int            last_beat_cyc = -1;
  int            first_valid_cyc = -1;
  bit            addr_oob = 0;

  std_mem_d1_reader #(.WIDTH(W), .SIZE(SZ), .IDX_SIZE(IW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .go             (go),
    .base_addr      (base_addr),
    .len            (len),
    .mem_addr0      (mem_addr0),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    mem_read_data = 32'hDEAD_BEEF;
    if (mem_addr0 < 5'd16) mem_read_data = mem[mem_addr0[3:0]];
  end

  // Stream monitor: every transferred beat is popped from the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_addr0 >= 5'd16) addr_oob = 1;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        beats = beats + 1;
        last_beat_cyc = cyc;
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL beat_unexpected: got data %0d, required no beat", out_data);
        end else begin
          mon_e = q.pop_front();
          n_cmp++;
          if (out_data !== mon_e.data) begin
            n_bad++;
            $display("FAIL beat_data: got %0d, required %0d", out_data, mon_e.data);
          end
          n_cmp++;
          if (out_last !== mon_e.last) begin
            n_bad++;
            $display("FAIL beat_last: got %b, required %b (data %0d)", out_last, mon_e.last, mon_e.data);
          end
`ifndef STD_MEM_D1_READER_OUT_REG_EN
          n_cmp++;
          if (mem_addr0 !== mon_e.addr) begin
            n_bad++;
            $display("FAIL beat_addr: got %0d, required %0d", mem_addr0, mon_e.addr);
          end
`endif
        end
        $display("beat %0d: cyc=%0d data=%0d last=%b", beats, cyc, out_data, out_last);
      end
    end
  end

  task automatic push_expect(input int b, input int l);
    int a;
    int n;
    beat_t e;
    a = b;
    n = (l > SZ) ? SZ : l;
    for (int i = 0; i < n; i++) begin
      e.data = 32'(a + 100);
      e.last = (i == n - 1);
      e.addr = IW'(a);
      q.push_back(e);
      a = (a == SZ - 1) ? 0 : a + 1;
    end
  endtask

  task automatic start_go(input int b, input int l, output int go_cyc);
    @(posedge clk); #1;
    go = 1'b1;
    base_addr = IW'(b);
    len = (IW+1)'(l);
    go_cyc = cyc;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(output int dcyc, output logic derr, output bit ok);
    ok = 0; dcyc = -1; derr = 1'bx;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcyc = cyc; derr = err; ok = 1;
        break;
      end
    end
  endtask

  task automatic clear_stats();
    beats = 0; last_beat_cyc = -1; first_valid_cyc = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_last, busy, done, err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b, required 00000", {out_valid, out_last, busy, done, err});
    end
    n_cmp++;
    if (mem_addr0 !== '0 || out_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got addr %0d data %0d, required 0 0", mem_addr0, out_data);
    end
    n_cmp++;
    if (mem_write_en !== 1'b0 || mem_write_data !== '0) begin
      n_bad++;
      $display("FAIL reset_write: got en %b data %0d, required 0 0", mem_write_en, mem_write_data);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int n; int d; logic e; bit ok;
    clear_stats();
    push_expect(3, 4);
    start_go(3, 4, n);
    wait_done(d, e, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_done_timeout: got no done, required done"); end
    n_cmp++;
    if (first_valid_cyc !== n + LAT) begin
      n_bad++; $display("FAIL basic_first_valid: got cyc %0d, required %0d", first_valid_cyc, n + LAT);
    end
    n_cmp++;
    if (beats !== 4 || q.size() !== 0) begin
      n_bad++; $display("FAIL basic_beats: got %0d (left %0d), required 4 (left 0)", beats, q.size());
    end
    n_cmp++;
    if (d !== last_beat_cyc + 1 || e !== 1'b0) begin
      n_bad++; $display("FAIL basic_done: got cyc %0d err %b, required cyc %0d err 0", d, e, last_beat_cyc + 1);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_after_done: got done %b busy %b, required 0 0", done, busy);
    end
    $display("test_basic: go=%0d done=%0d beats=%0d", n, d, beats);
  endtask

  task automatic test_wrap();
    int n; int d; logic e; bit ok;
    clear_stats();
    addr_oob = 0;
    push_expect(14, 4);
    start_go(14, 4, n);
    wait_done(d, e, ok);
    n_cmp++;
    if (!ok || beats !== 4 || q.size() !== 0) begin
      n_bad++; $display("FAIL wrap_beats: got %0d done_seen %0d, required 4 beats with done", beats, ok);
    end
    n_cmp++;
    if (addr_oob !== 1'b0) begin
      n_bad++; $display("FAIL wrap_addr_range: got address >= %0d, required all below", SZ);
    end
    $display("test_wrap: go=%0d done=%0d beats=%0d", n, d, beats);
  endtask

  task automatic test_stall();
    int n; int d; logic e; bit ok;
    bit pat [5];
    bit stalled;
    logic [W-1:0] held_d;
    logic held_l;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    stalled = 0; held_d = '0; held_l = 1'b0;
    clear_stats();
    push_expect(0, 3);
    start_go(0, 3, n);
    if (LAT == 2) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      out_ready = pat[i];
      @(negedge clk);
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
          n_bad++;
          $display("FAIL stall_hold: got v%b d%0d l%b, required v1 d%0d l%b", out_valid, out_data, out_last, held_d, held_l);
        end
      end
      stalled = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done(d, e, ok);
    n_cmp++;
    if (!ok || beats !== 3 || q.size() !== 0) begin
      n_bad++; $display("FAIL stall_beats: got %0d done_seen %0d, required 3 beats with done", beats, ok);
    end
    n_cmp++;
    if (d !== last_beat_cyc + 1) begin
      n_bad++; $display("FAIL stall_done_cyc: got %0d, required %0d", d, last_beat_cyc + 1);
    end
    $display("test_stall: go=%0d done=%0d beats=%0d", n, d, beats);
  endtask

  task automatic test_zero_and_err();
    int n; int d; logic e; bit ok;
    clear_stats();
    start_go(0, 0, n);
    wait_done(d, e, ok);
    n_cmp++;
    if (!ok || d !== n + 2 || e !== 1'b0) begin
      n_bad++; $display("FAIL zero_done: got cyc %0d err %b, required cyc %0d err 0", d, e, n + 2);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL zero_pulse: got done %b, required 0", done);
    end
    start_go(20, 4, n);
    wait_done(d, e, ok);
    n_cmp++;
    if (!ok || e !== 1'b1) begin
      n_bad++; $display("FAIL err_done: got done_seen %0d err %b, required 1 1", ok, e);
    end
    n_cmp++;
    if (first_valid_cyc !== -1 || beats !== 0) begin
      n_bad++; $display("FAIL zero_err_valid: got first valid cyc %0d beats %0d, required none", first_valid_cyc, beats);
    end
    $display("test_zero_and_err: err go=%0d done=%0d", n, d);
  endtask

  task automatic test_long();
    int n; int d; logic e; bit ok;
    clear_stats();
    push_expect(5, 31);
    start_go(5, 31, n);
    repeat (5) @(posedge clk);
    #1;
    go = 1'b1; base_addr = '0; len = 6'd2;
    @(posedge clk); #1;
    go = 1'b0;
    wait_done(d, e, ok);
    n_cmp++;
    if (!ok || beats !== 16 || q.size() !== 0) begin
      n_bad++; $display("FAIL long_beats: got %0d (left %0d), required 16 (left 0)", beats, q.size());
    end
    n_cmp++;
    if (d !== last_beat_cyc + 1 || e !== 1'b0) begin
      n_bad++; $display("FAIL long_done: got cyc %0d err %b, required cyc %0d err 0", d, e, last_beat_cyc + 1);
    end
    $display("test_long: go=%0d done=%0d beats=%0d", n, d, beats);
  endtask

  task automatic test_reset_mid();
    int n; int d; logic e; bit ok; bit saw_done;
    clear_stats();
    push_expect(2, 8);
    start_go(2, 8, n);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (beats >= 2) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mid_beats_timeout: got %0d beats, required 2", beats); end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_last, busy, done, err} !== 5'b0 || mem_addr0 !== '0 || out_data !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got ctrl %b addr %0d data %0d, required 0", {out_valid, out_last, busy, done, err}, mem_addr0, out_data);
    end
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    saw_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1;
    end
    n_cmp++;
    if (saw_done) begin n_bad++; $display("FAIL mid_no_done: got done after abort, required none"); end
    clear_stats();
    push_expect(9, 2);
    start_go(9, 2, n);
    wait_done(d, e, ok);
    n_cmp++;
    if (!ok || beats !== 2 || q.size() !== 0 || first_valid_cyc !== n + LAT) begin
      n_bad++;
      $display("FAIL mid_fresh: got beats %0d first valid %0d, required 2 at %0d", beats, first_valid_cyc, n + LAT);
    end
    $display("test_reset_mid: fresh go=%0d done=%0d beats=%0d", n, d, beats);
  endtask

  initial begin
    for (int i = 0; i < SZ; i++) mem[i] = 32'(i + 100);
    reset_n = 1'b1;
    go = 1'b0;
    base_addr = '0;
    len = '0;
    out_ready = 1'b1;
    #1;
    reset_n = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_and_err();
    test_long();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/std_mem_d1_reader.md
Name: std_mem_d1_reader

Overview:
- Initiator-side companion to the 1-D memory primitive. It drives addr0, write_data and write_en on the memory and samples its combinational read_data.
- It walks a contiguous address range, with wrap-around, and presents each word on a valid/ready output stream.
- It is controlled by the standard go/done pulse interface, so a Calyx component can drain a memory into a streaming consumer.

Parameters:
- WIDTH, 32, data word width; must match the attached memory.
- SIZE, 16, number of memory words.
- IDX_SIZE, 4, address width; must satisfy 2^IDX_SIZE >= SIZE.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- go  input  1  start request; sampled only in IDLE.
- base_addr  input  IDX_SIZE  first address; sampled with go.
- len  input  IDX_SIZE+1  number of words to read; sampled with go.
- mem_addr0  output  IDX_SIZE  address driven to the memory.
- mem_write_data  output  WIDTH  constant 0.
- mem_write_en  output  1  constant 0; the block never writes.
- mem_read_data  input  WIDTH  combinational read data from the memory.
- out_data  output  WIDTH  stream payload.
- out_valid  output  1  payload valid.
- out_ready  input  1  consumer ready.
- out_last  output  1  marks the final beat of a transfer.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  qualifies done; high when base_addr was out of range.

Behaviour:
- Reset (async assert, sync release):
  - state goes to IDLE.
  - out_valid, out_last, busy, done, err, mem_addr0 and out_data all go to 0.
  - Reset during a transfer aborts it; no done pulse is produced.
- States: IDLE, READ, FIN.
- IDLE:
  - go=1 and base_addr >= SIZE: go to FIN with err_q=1.
  - Otherwise, go=1 and len=0: go to FIN with err_q=0.
  - Otherwise, go=1: cur=base_addr, rem=min(len,SIZE), go to READ.
- READ:
  - mem_addr0=cur; out_data=mem_read_data; out_valid=1; out_last=(rem==1).
  - A beat transfers when out_valid && out_ready.
  - On a beat: rem-=1; cur = (cur==SIZE-1) ? 0 : cur+1. Wrap is at SIZE, not at 2^IDX_SIZE.
  - The beat with rem==1 goes to FIN.
  - While out_ready=0, out_data, out_last and mem_addr0 hold stable.
- FIN: done=1 and err=err_q for exactly one cycle, then go to IDLE.
- go is ignored outside IDLE.
- A new go is accepted in the cycle after done.
- Latency:
  - go at cycle N gives first out_valid at cycle N+1.
  - With out_ready held high, one beat per cycle.
  - done is asserted in the cycle after the last beat.
- mem_addr0 holds its last value in IDLE and FIN.
- Memory contents must not change during a transfer; this is a caller obligation.

Optional Feature:
- Macro: STD_MEM_D1_READER_OUT_REG_EN.
- Defined:
  - out_data and out_last come from a one-entry output register stage.
  - The memory is read into the stage when it is empty or being drained that cycle.
  - First out_valid is at cycle N+2 after go. Throughput stays one beat per cycle.
  - done follows the last out-stage beat by one cycle.
  - out_data has no combinational path from mem_read_data.
- Undefined: the combinational behaviour described above.

Decomposition:
- Package std_mem_reader_pkg:
  - state enum typedef (IDLE, READ, FIN), 2 bits.
  - helper function next_addr(cur, SIZE) for the wrap rule.
- Sub-module std_mem_reader_out_stage: the one-entry valid/ready register. It is instantiated only under STD_MEM_D1_READER_OUT_REG_EN.

Test Plan:
1. Memory preloaded with mem[i]=i+100, base=3, len=4, out_ready=1 -> beats 103,104,105,106; out_last on 106; done in the following cycle; err=0.
2. SIZE=16, base=14, len=4 -> addresses 14,15,0,1; data 114,115,100,101. No access to address 16.
3. base=0, len=3, out_ready toggling 1,0,0,1,1 -> out_data holds during stalls; exactly 3 beats; done one cycle after the third beat.
4. len=0 -> no out_valid; done=1 at cycle N+2; err=0. Then base=20 with SIZE=16 -> done with err=1.
5. len=31 with SIZE=16 -> exactly 16 beats; go pulsed again mid-transfer is ignored.
6. reset_n asserted mid-transfer after 2 beats -> all outputs 0 immediately; no done. The next go behaves as a fresh transfer.
